// File: rtl/mmcm_sim_multi.sv
// mmcm_sim_multi: cycle-based behavioural model of a multi-output clock manager.
// Derives NUM_OUT divided clocks from CLKIN1. Each channel has its own integer
// divide and phase offset. LOCKED rises after LOCK_CYCLES edges, and every
// output is held low until lock. This is a simulation model only.
// Optional feature: define MMCM_SIM_CE_OUT_EN to add the CLKOUT_CE port. It
// gives a one-cycle pulse per output period, at channel count zero.
module mmcm_sim_multi #(
  parameter int                     NUM_OUT     = 4,
  parameter logic [8*NUM_OUT-1:0]   DIVIDE_VEC  = {8'd8, 8'd6, 8'd4, 8'd2},
  parameter logic [8*NUM_OUT-1:0]   PHASE_VEC   = '0,
  parameter int                     LOCK_CYCLES = 16
) (
  input  logic               CLKIN1,
  input  logic               RST,
  input  logic               PWRDWN,
  output logic [NUM_OUT-1:0] CLKOUT,
`ifdef MMCM_SIM_CE_OUT_EN
  output logic [NUM_OUT-1:0] CLKOUT_CE,
`endif
  output logic               LOCKED
);

  // ---------------------------------------------------------------------------
  // Elaboration-time configuration checks
  // ---------------------------------------------------------------------------
  if (NUM_OUT < 1 || NUM_OUT > 8) begin : g_bad_num_out
    $fatal(1, "mmcm_sim_multi: NUM_OUT must be in 1..8");
  end

  if (LOCK_CYCLES < 1 || LOCK_CYCLES > 65535) begin : g_bad_lock
    $fatal(1, "mmcm_sim_multi: LOCK_CYCLES must be in 1..65535");
  end

  for (genvar c = 0; c < NUM_OUT; c++) begin : g_chk
    if (DIVIDE_VEC[8*c +: 8] < 8'd2) begin : g_bad_div
      $fatal(1, "mmcm_sim_multi: channel divide below 2");
    end
    if (PHASE_VEC[8*c +: 8] >= DIVIDE_VEC[8*c +: 8]) begin : g_bad_phase
      $fatal(1, "mmcm_sim_multi: channel phase not below its divide");
    end
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------

  // Next value of a channel phase counter once locked: wrap at divide-1.
  function automatic logic [7:0] cnt_advance(input logic [7:0] cnt,
                                             input logic [7:0] last);
    logic [7:0] nxt;
    if (cnt == last) begin
      nxt = 8'd0;
    end else begin
      nxt = cnt + 8'd1;
    end
    return nxt;
  endfunction

  // Saturating increment of the lock counter.
  function automatic logic [15:0] lock_advance(input logic [15:0] cnt,
                                               input logic [15:0] tgt);
    logic [15:0] nxt;
    if (cnt >= tgt) begin
      nxt = tgt;
    end else begin
      nxt = cnt + 16'd1;
    end
    return nxt;
  endfunction

  // ---------------------------------------------------------------------------
  // Lock tracking
  // ---------------------------------------------------------------------------
  localparam logic [15:0] LOCK_TGT = LOCK_CYCLES[15:0];

  // RST and PWRDWN have the same effect, so they are merged into one reset.
  logic        rst_s;
  logic [15:0] lock_cnt_r;
  logic [15:0] lock_cnt_nxt_s;
  logic        locked_r;
  logic        locked_nxt_s;

  assign rst_s = RST | PWRDWN;

  // Next lock count. LOCKED rises on the same edge that the count reaches the target.
  always_comb begin
    lock_cnt_nxt_s = lock_advance(lock_cnt_r, LOCK_TGT);
    if (lock_cnt_nxt_s == LOCK_TGT) begin
      locked_nxt_s = 1'b1;
    end else begin
      locked_nxt_s = 1'b0;
    end
  end

  // Lock counter and registered LOCKED. Any reset restarts the full settle wait.
  always_ff @(posedge CLKIN1) begin
    if (rst_s) begin
      lock_cnt_r <= 16'd0;
      locked_r   <= 1'b0;
    end else begin
      lock_cnt_r <= lock_cnt_nxt_s;
      locked_r   <= locked_nxt_s;
    end
  end

  assign LOCKED = locked_r;

  // ---------------------------------------------------------------------------
  // Output channels
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < NUM_OUT; i++) begin : g_ch
    localparam logic [7:0] DIV_C  = DIVIDE_VEC[8*i +: 8];
    localparam logic [7:0] PH_C   = PHASE_VEC[8*i +: 8];
    localparam logic [7:0] LAST_C = DIV_C - 8'd1;
    localparam logic [7:0] HIGH_C = DIV_C >> 1;   // odd divides bias low

    logic [7:0] cnt_r;
    logic [7:0] cnt_nxt_s;
    logic       clk_r;
    logic       clk_nxt_s;
    logic       ce_r;
    logic       ce_nxt_s;

    // Counter next-state. It parks at the phase offset until lock, so all
    // channels start counting together from the LOCKED edge.
    always_comb begin
      if (locked_r) begin
        cnt_nxt_s = cnt_advance(cnt_r, LAST_C);
      end else begin
        cnt_nxt_s = PH_C;
      end
    end

    // Output levels are taken from the current register values. This makes the
    // first valid level appear one edge after LOCKED and avoids a runt pulse.
    always_comb begin
      if (locked_r) begin
        clk_nxt_s = (cnt_r < HIGH_C);
        ce_nxt_s  = (cnt_r == 8'd0);
      end else begin
        clk_nxt_s = 1'b0;
        ce_nxt_s  = 1'b0;
      end
    end

    // Channel registers. Reset reloads the phase offset and forces outputs low.
    always_ff @(posedge CLKIN1) begin
      if (rst_s) begin
        cnt_r <= PH_C;
        clk_r <= 1'b0;
        ce_r  <= 1'b0;
      end else begin
        cnt_r <= cnt_nxt_s;
        clk_r <= clk_nxt_s;
        ce_r  <= ce_nxt_s;
      end
    end

    assign CLKOUT[i] = clk_r;

`ifdef MMCM_SIM_CE_OUT_EN
    assign CLKOUT_CE[i] = ce_r;
`else
    // Without the CE port the enable register has no load and is trimmed away.
    logic ce_unused_s;
    assign ce_unused_s = ce_r;
`endif
  end

endmodule

// File: tb/tb_mmcm_sim_multi.sv
// tb_mmcm_sim_multi: directed bench for mmcm_sim_multi.
// Six channels are used: ch0 D=4 P=0, ch1 D=4 P=1, ch2 D=2, ch3 D=3, ch4 D=6, ch5 D=8.
module tb_mmcm_sim_multi;

  localparam int N     = 6;
  localparam int LOCKN = 16;

  localparam logic [8*N-1:0] DIV = {8'd8, 8'd6, 8'd3, 8'd2, 8'd4, 8'd4};
  localparam logic [8*N-1:0] PH  = {8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0};

  int dv [N] = '{4, 4, 2, 3, 6, 8};
  int pv [N] = '{0, 1, 0, 0, 0, 0};

  // Hand-computed CLKOUT for the first six edges after lock (edges 17..22).
  logic [N-1:0] first_pat [6] = '{6'b111111, 6'b110001, 6'b110100,
                                  6'b101010, 6'b000111, 6'b000001};

  logic         clk = 1'b0;
  logic         rst;
  logic         pwrdwn;
  logic [N-1:0] clkout;
  logic         locked;
  logic [N-1:0] ce_obs;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mmcm_sim_multi #(
    .NUM_OUT    (N),
    .DIVIDE_VEC (DIV),
    .PHASE_VEC  (PH),
    .LOCK_CYCLES(LOCKN)
  ) dut (
    .CLKIN1   (clk),
    .RST      (rst),
    .PWRDWN   (pwrdwn),
    .CLKOUT   (clkout),
`ifdef MMCM_SIM_CE_OUT_EN
    .CLKOUT_CE(ce_obs),
`endif
    .LOCKED   (locked)
  );

`ifndef MMCM_SIM_CE_OUT_EN
  assign ce_obs = '0;
`endif

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected model outputs k edges after the first valid output edge.
  function automatic logic [N-1:0] exp_clk(input int k);
    logic [N-1:0] v;
    for (int c = 0; c < N; c++) v[c] = (((k + pv[c]) % dv[c]) < (dv[c] / 2));
    return v;
  endfunction

  function automatic logic [N-1:0] exp_ce(input int k);
    logic [N-1:0] v;
    for (int c = 0; c < N; c++) v[c] = (((k + pv[c]) % dv[c]) == 0);
    return v;
  endfunction

  // Hold the reset inputs for n edges and check that everything stays quiet.
  task automatic hold_reset(input string tag, input logic r, input logic p, input int n);
    rst = r; pwrdwn = p;
    for (int e = 1; e <= n; e++) begin
      tick();
      chk($sformatf("%s locked e%0d", tag, e), 32'(locked), 32'd0);
      chk($sformatf("%s clkout e%0d", tag, e), 32'(clkout), 32'd0);
      chk($sformatf("%s ce e%0d", tag, e), 32'(ce_obs), 32'd0);
    end
    rst = 1'b0; pwrdwn = 1'b0;
  endtask

  // Release from reset: LOCKED at edge 16, then the fixed pattern table.
  task automatic relock(input string tag);
    for (int e = 1; e <= LOCKN; e++) begin
      tick();
      chk($sformatf("%s locked e%0d", tag, e), 32'(locked), 32'(e == LOCKN));
      chk($sformatf("%s clkout e%0d", tag, e), 32'(clkout), 32'd0);
      chk($sformatf("%s ce e%0d", tag, e), 32'(ce_obs), 32'd0);
    end
    for (int j = 0; j < 6; j++) begin
      tick();
      chk($sformatf("%s pat e%0d", tag, LOCKN + 1 + j), 32'(clkout), 32'(first_pat[j]));
      chk($sformatf("%s locked e%0d", tag, LOCKN + 1 + j), 32'(locked), 32'd1);
`ifdef MMCM_SIM_CE_OUT_EN
      chk($sformatf("%s ce e%0d", tag, LOCKN + 1 + j), 32'(ce_obs), 32'(exp_ce(j)));
`endif
    end
  endtask

  // Free run after relock (which ends at k=5). It checks the model every edge and
  // measures each channel's period, high time and the ch1-leads-ch0 phase.
  task automatic long_run(input string tag, input int n);
    int k;
    int mm;
    int ph_bad;
    int ch0_rises;
    logic ch1_rose_prev;
    logic [N-1:0] prev;
    int last_rise [N];
    int pmin [N];
    int pmax [N];
    int hmin [N];
    int hmax [N];
    int rises [N];
    k = 6; mm = 0; ph_bad = 0; ch0_rises = 0; ch1_rose_prev = 1'b0;
    prev = clkout;
    for (int c = 0; c < N; c++) begin
      last_rise[c] = -1; pmin[c] = 1000; pmax[c] = 0;
      hmin[c] = 1000; hmax[c] = 0; rises[c] = 0;
    end
    for (int t = 0; t < n; t++) begin
      tick();
      if (clkout !== exp_clk(k)) mm++;
      if (locked !== 1'b1) mm++;
`ifdef MMCM_SIM_CE_OUT_EN
      if (ce_obs !== exp_ce(k)) mm++;
`endif
      for (int c = 0; c < N; c++) begin
        if (!prev[c] && clkout[c]) begin
          if (last_rise[c] >= 0) begin
            if (t - last_rise[c] < pmin[c]) pmin[c] = t - last_rise[c];
            if (t - last_rise[c] > pmax[c]) pmax[c] = t - last_rise[c];
          end
          last_rise[c] = t;
          rises[c]++;
        end else if (prev[c] && !clkout[c] && last_rise[c] >= 0) begin
          if (t - last_rise[c] < hmin[c]) hmin[c] = t - last_rise[c];
          if (t - last_rise[c] > hmax[c]) hmax[c] = t - last_rise[c];
        end
      end
      if (!prev[0] && clkout[0]) begin
        ch0_rises++;
        if (!ch1_rose_prev) ph_bad++;
      end
      ch1_rose_prev = !prev[1] && clkout[1];
      prev = clkout;
      k++;
    end
    chk($sformatf("%s model", tag), 32'(mm), 32'd0);
    chk($sformatf("%s phase lead", tag), 32'(ph_bad), 32'd0);
    chk($sformatf("%s ch0 rose", tag), 32'(ch0_rises > 0), 32'd1);
    for (int c = 0; c < N; c++) begin
      chk($sformatf("%s ch%0d pmin", tag, c), 32'(pmin[c]), 32'(dv[c]));
      chk($sformatf("%s ch%0d pmax", tag, c), 32'(pmax[c]), 32'(dv[c]));
      chk($sformatf("%s ch%0d hmin", tag, c), 32'(hmin[c]), 32'(dv[c] / 2));
      chk($sformatf("%s ch%0d hmax", tag, c), 32'(hmax[c]), 32'(dv[c] / 2));
      chk($sformatf("%s ch%0d rises", tag, c), 32'(rises[c] >= (n / dv[c]) - 1), 32'd1);
    end
  endtask

  initial begin
    rst = 1'b1;
    pwrdwn = 1'b0;
    hold_reset("init", 1'b1, 1'b0, 3);
    relock("lock1");
    long_run("run1", 820);

    // A one-cycle RST pulse mid-operation.
    hold_reset("rstpulse", 1'b1, 1'b0, 1);
    relock("lock2");
    long_run("run2", 44);

    // Power-down alone, then together with RST.
    hold_reset("pwrdwn", 1'b0, 1'b1, 10);
    relock("lock3");
    long_run("run3", 30);
    hold_reset("both", 1'b1, 1'b1, 10);
    relock("lock4");
    long_run("run4", 24);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
